// File: rtl/note_player_if.sv
// Note request / status bundle between a melody sequencer and the note player.
// master: sequencer side (drives request); slave: player side (drives status).
interface note_player_if #(
   parameter int CNT_W = 26,
   parameter int DUR_W = 16
);
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] half_period;
   logic [DUR_W-1:0] duration_ms;
   logic             busy;
   logic             done;
   logic             tone_out;

   modport master (
      output start, stop, half_period, duration_ms,
      input  busy, done, tone_out
   );

   modport slave (
      input  start, stop, half_period, duration_ms,
      output busy, done, tone_out
   );
endinterface

// File: rtl/note_player.sv
// Single-note square-wave player: half-period and ms duration latched per request.
// Ports: clk_50MHz, reset_button (sync, active-low), bus (note_player_if.slave).
module note_player #(
   parameter int CNT_W    = 26,
   parameter int DUR_W    = 16,
   parameter int TICK_DIV = 50000
) (
   input logic           clk_50MHz,
   input logic           reset_button,
   note_player_if.slave  bus
);
   localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PLAY = 1'b1;

   logic [0:0]        state_q;
   logic [CNT_W-1:0]  hp_q;
   logic [DUR_W-1:0]  rem_q;
   logic [CNT_W-1:0]  tone_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic              tone_q;
   logic              done_q;

   always_ff @(posedge clk_50MHz) begin
      if (!reset_button) begin
         state_q  <= IDLE;
         hp_q     <= '0;
         rem_q    <= '0;
         tone_cnt <= '0;
         tick_cnt <= '0;
         tone_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // stop in the same cycle drops the request entirely
               if (bus.start && !bus.stop) begin
                  hp_q     <= bus.half_period;
                  rem_q    <= bus.duration_ms;
                  tone_cnt <= '0;
                  tick_cnt <= '0;
                  tone_q   <= 1'b0;
                  if (bus.duration_ms == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= PLAY;
                  end
               end
            end
            PLAY: begin
               if (bus.stop) begin
                  state_q  <= IDLE;
                  tone_q   <= 1'b0;
                  tone_cnt <= '0;
                  tick_cnt <= '0;
               end else begin
                  // hp_q == 0 is a rest: counter and output stay parked
                  if (hp_q != '0) begin
                     if (tone_cnt == hp_q) begin
                        tone_cnt <= '0;
                        tone_q   <= ~tone_q;
                     end else begin
                        tone_cnt <= tone_cnt + 1'b1;
                     end
                  end
                  if (tick_cnt == TICK_MAX) begin
                     tick_cnt <= '0;
                     rem_q    <= rem_q - 1'b1;
                     if (rem_q == DUR_W'(1)) begin
                        state_q  <= IDLE;
                        tone_q   <= 1'b0;
                        tone_cnt <= '0;
                        done_q   <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy     = (state_q == PLAY);
   assign bus.done     = done_q;
   assign bus.tone_out = tone_q;
endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player (TICK_DIV=10): vector table, corner
// sequences and random traffic against an elapsed-time reference model.
module tb_note_player;
   localparam int T = 10;

   logic clk = 1'b0;
   logic rst_n;

   note_player_if #(.CNT_W(26), .DUR_W(16)) bus ();

   note_player #(.CNT_W(26), .DUR_W(16), .TICK_DIV(T)) dut (
      .clk_50MHz    (clk),
      .reset_button (rst_n),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: note described by accept parameters and elapsed edges
   bit m_active = 0;
   int m_k      = 0;
   int m_hp     = 0;
   int m_len    = 0;
   bit m_done   = 0;
   bit m_busy, m_tone;

   int cnt_busy, cnt_done, cnt_tone;

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model();
      m_done = 0;
      if (!rst_n) begin
         m_active = 0;
         m_k      = 0;
      end else if (m_active) begin
         if (bus.stop) begin
            m_active = 0;
         end else begin
            m_k++;
            if (m_k == m_len) begin
               m_active = 0;
               m_done   = 1;
            end
         end
      end else if (bus.start && !bus.stop) begin
         m_hp  = int'(bus.half_period);
         m_len = int'(bus.duration_ms) * T;
         m_k   = 0;
         if (m_len == 0) m_done = 1;
         else m_active = 1;
      end
      m_busy = m_active;
      m_tone = (m_active && m_hp != 0) ? (((m_k / (m_hp + 1)) % 2) == 1) : 1'b0;
   endtask

   task automatic step(string tag);
      @(posedge clk);
      model();
      #1;
      check({tag, " busy"}, int'(bus.busy), int'(m_busy));
      check({tag, " done"}, int'(bus.done), int'(m_done));
      check({tag, " tone"}, int'(bus.tone_out), int'(m_tone));
      cnt_busy += int'(bus.busy);
      cnt_done += int'(bus.done);
      cnt_tone += int'(bus.tone_out);
   endtask

   task automatic clr();
      cnt_busy = 0;
      cnt_done = 0;
      cnt_tone = 0;
   endtask

   task automatic req(bit s, bit p, int hp, int dur);
      bus.start       = s;
      bus.stop        = p;
      bus.half_period = 26'(hp);
      bus.duration_ms = 16'(dur);
   endtask

   typedef struct {
      bit stop;
      int hp;
      int dur;
      int exp_busy;
      int exp_done;
      int exp_tone;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{0, 2, 3, 30, 1, 15};
      vecs[1] = '{0, 0, 2, 20, 1, 0};
      vecs[2] = '{0, 5, 0, 0, 1, 0};
      vecs[3] = '{0, 1, 1, 10, 1, 4};
      vecs[4] = '{1, 2, 3, 0, 0, 0};

      // reset held with start requested
      rst_n = 1'b0;
      req(1, 0, 2, 3);
      clr();
      repeat (3) step("reset");
      check("reset busy cnt", cnt_busy, 0);
      rst_n = 1'b1;
      req(0, 0, 2, 3);
      clr();
      repeat (5) step("post_reset");
      check("post_reset busy cnt", cnt_busy, 0);

      foreach (vecs[i]) begin
         req(1, vecs[i].stop, vecs[i].hp, vecs[i].dur);
         clr();
         step($sformatf("vec%0d", i));
         req(0, 0, 0, 0);
         repeat (40) step($sformatf("vec%0d", i));
         check($sformatf("vec%0d busy cycles", i), cnt_busy, vecs[i].exp_busy);
         check($sformatf("vec%0d done pulses", i), cnt_done, vecs[i].exp_done);
         check($sformatf("vec%0d tone highs", i), cnt_tone, vecs[i].exp_tone);
      end

      // abort mid-note
      req(1, 0, 4, 5);
      clr();
      step("abort");
      req(0, 0, 4, 5);
      repeat (16) step("abort");
      bus.stop = 1'b1;
      step("abort");
      check("abort busy", int'(bus.busy), 0);
      check("abort tone", int'(bus.tone_out), 0);
      bus.stop = 1'b0;
      repeat (10) step("abort");
      check("abort done cnt", cnt_done, 0);

      // abort on the final tick edge
      req(1, 0, 4, 1);
      clr();
      step("abort_last");
      req(0, 0, 4, 1);
      repeat (9) step("abort_last");
      bus.stop = 1'b1;
      step("abort_last");
      bus.stop = 1'b0;
      repeat (5) step("abort_last");
      check("abort_last done cnt", cnt_done, 0);
      check("abort_last busy", int'(bus.busy), 0);

      // start ignored while busy
      req(1, 0, 2, 2);
      clr();
      step("ignore");
      req(1, 0, 7, 1);
      repeat (19) step("ignore");
      req(0, 0, 0, 0);
      repeat (3) step("ignore");
      check("ignore tone highs", cnt_tone, 9);
      check("ignore busy cycles", cnt_busy, 20);

      // chaining in the done cycle
      begin
         bit seen = 0;
         req(1, 0, 1, 1);
         step("chain");
         req(0, 0, 0, 0);
         for (int c = 0; c < 30 && !seen; c++) begin
            step("chain");
            if (bus.done) seen = 1;
         end
         check("chain done seen", int'(seen), 1);
         check("chain done-cycle busy", int'(bus.busy), 0);
         req(1, 0, 3, 1);
         step("chain");
         check("chain second busy", int'(bus.busy), 1);
         req(0, 0, 0, 0);
         repeat (15) step("chain");
      end

      // random traffic
      for (int n = 0; n < 600; n++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         req(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
         step("rand");
      end
      rst_n = 1'b1;
      req(0, 0, 0, 0);
      repeat (45) step("drain");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Parametrised successor to the fixed 415 Hz buzzer divider in the music-buzz design.
- Plays one note per request: a square wave whose half-period is loaded at run time, for a programmed duration in milliseconds.
- Returns to idle after each note and pulses done, so a melody sequencer upstream can chain notes back to back.
- Sits between the sequencer and the buzzer pin.

Parameters:
- CNT_W, 26: width of the half-period counter and of the half_period input.
- DUR_W, 16: width of duration_ms and of the remaining-duration counter.
- TICK_DIV, 50000: clk_50MHz cycles per millisecond tick; must be >= 2.

Ports:
- clk_50MHz  input  1  system clock; all logic on the rising edge.
- reset_button  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk_50MHz.
- start  input  1  note request; accepted only when busy=0.
- stop  input  1  abort the current note.
- half_period  input  CNT_W  tone half-period minus one, in clocks; 0 = rest (silent note).
- duration_ms  input  DUR_W  note length in ms ticks.
- busy  output  1  note in progress.
- done  output  1  one-cycle pulse when a note completes normally.
- tone_out  output  1  square wave to the buzzer.

Behaviour:
- Reset (reset_button=0 at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, tone_out=0.
  - All counters and latched values go to 0.
  - Reset overrides every other input in the same cycle, including mid-note.
- States: IDLE and PLAY. All outputs are registered.
- IDLE, start=1, stop=0:
  - Latch half_period into hp_q and duration_ms into rem_q.
  - Clear the tone counter, tick counter and tone_out.
  - If duration_ms=0: stay in IDLE and assert done=1 on the next cycle; busy stays 0.
  - Otherwise go to PLAY; busy=1 from the next cycle.
- IDLE, start=1 and stop=1 in the same cycle: stop wins, the request is dropped and there is no done pulse.
- PLAY, tone generation:
  - The tone counter counts 0..hp_q.
  - When it equals hp_q: it returns to 0 and tone_out toggles.
  - Result: period = 2*(hp_q+1) clocks, frequency = 50e6/(2*(hp_q+1)).
  - The first rising edge of tone_out appears hp_q+1 cycles after entering PLAY.
  - hp_q=0 is a rest: tone_out is held 0 and the tone counter is idle.
- PLAY, duration:
  - The tick counter counts 0..TICK_DIV-1 and wraps.
  - On each wrap, rem_q decrements by 1.
  - When a wrap occurs with rem_q=1: go to IDLE, tone_out=0, busy=0, done=1 for exactly one cycle.
  - PLAY therefore lasts exactly duration_ms*TICK_DIV cycles.
- start while busy=1: ignored. Input changes during PLAY have no effect because values are latched at acceptance.
- stop in PLAY: next cycle IDLE, tone_out=0, busy=0, done=0.
  - stop on the same edge as the final tick still counts as an abort: no done.
- Back-to-back notes:
  - start is accepted in the cycle done=1, since busy=0 then.
  - The gap between notes is 1 cycle of IDLE.
- Wrap-around: the counters never overflow; the terminal compare is equality against hp_q and TICK_DIV-1.
- Latency: start to busy = 1 cycle; final tick to done = 1 cycle.

Test Plan (TICK_DIV=10 unless stated):
- Reset: hold reset_button=0 for 3 cycles with start=1 -> busy=0, done=0, tone_out=0 throughout; no note starts after release until a fresh start.
- Basic note: half_period=2, duration_ms=3, start pulse -> busy high for exactly 30 cycles; tone_out period 6 cycles (3 high, 3 low), first rise 3 cycles after busy rises; single done pulse as busy falls; tone_out=0 after.
- Rest and zero length:
  - half_period=0, duration_ms=2 -> tone_out stays 0, busy high 20 cycles, one done pulse.
  - duration_ms=0 -> busy never rises, done pulses 1 cycle after start.
- Abort: start half_period=4, duration_ms=5; assert stop at cycle 17 -> busy=0 and tone_out=0 next cycle, no done.
  - Repeat with stop on the final tick edge -> still no done.
- Ignore while busy and chaining:
  - start asserted repeatedly during a note with different half_period -> tone period unchanged.
  - start asserted in the done cycle -> new note begins with 1 idle cycle gap.
- Default parameters: half_period=60000, duration_ms=2 -> tone_out toggles every 60001 cycles; busy high for 100000 cycles.
